// File: rtl/priority_encoder_pkg.sv
// Shared types and helpers for the registered 8-to-3 priority encoder.
// Holds the FSM state enum, widths and the highest-index search.
package priority_encoder_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  // Highest set index; 0 when nothing is set.
  function automatic logic [CODE_W-1:0] prio_idx(
    input logic [REQ_W-1:0] v
  );
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_encoder_8to3_irq_sync.sv
// Multi-flop synchronizer, resets to all-ones (inactive for low-true lines).
// Ports: clk_i, rst_n_i, d_i (async in), q_o (synced out); STAGES=0 passes through.
module sync_ff_n #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (STAGES == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_sync
    logic [W-1:0] ff [STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < STAGES; i++) ff[i] <= '1;
      end else begin
        ff[0] <= d_i;
        for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
      end
    end

    assign q_o = ff[STAGES-1];
  end

endmodule

// File: rtl/priority_encoder_8to3_irq.sv
// Registered 8-to-3 priority encoder with sticky pending bits and ack handshake.
// Ports: req_n_i/ei_n_i/ack_i in; a_n_o, gs_n_o, valid_o, eo_n_o, pending_o out.
module priority_encoder_8to3_irq
  import priority_encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit STICKY      = 1'b1,
  parameter bit PREEMPT     = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REQ_W-1:0]  req_n_i,
  input  logic              ei_n_i,
  input  logic              ack_i,
  output logic [CODE_W-1:0] a_n_o,
  output logic              gs_n_o,
  output logic              valid_o,
  output logic              eo_n_o,
  output logic [REQ_W-1:0]  pending_o
);

  logic [REQ_W-1:0]  req_sn;
  logic [REQ_W-1:0]  req_s;
  logic [REQ_W-1:0]  req_q;
  logic [REQ_W-1:0]  pend_q;
  logic [REQ_W-1:0]  pend_d;
  logic [REQ_W-1:0]  clr;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_d;
  logic [CODE_W-1:0] top;
  logic [CODE_W-1:0] a_n_q;
  logic              gs_n_q;
  logic              eo_n_q;
  logic              en;
  logic              retire;
  state_e            st_q;
  state_e            st_d;

  sync_ff_n #(
    .W      (REQ_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (req_n_i),
    .q_o     (req_sn)
  );

  assign req_s  = ~req_sn;
  assign en     = ~ei_n_i;
  assign retire = (st_q == HOLD) & en & ack_i;
  assign top    = prio_idx(pend_q);

  // A new rising request ORs in after the clear, so it survives a retire.
  always_comb begin
    clr = '0;
    if (retire) clr[code_q] = 1'b1;
    if (STICKY) pend_d = (pend_q & ~clr) | (req_s & ~req_q);
    else        pend_d = req_s;
  end

  always_comb begin
    st_d   = st_q;
    code_d = code_q;
    unique case (st_q)
      IDLE: begin
        if (en && (pend_q != '0)) begin
          st_d   = HOLD;
          code_d = top;
        end
      end
      HOLD: begin
        if (!en || ack_i) begin
          st_d = IDLE;
        end else if (PREEMPT && (top > code_q)) begin
          code_d = top;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q   <= IDLE;
      code_q <= '0;
      pend_q <= '0;
      req_q  <= '0;
      a_n_q  <= '1;
      gs_n_q <= 1'b1;
      eo_n_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      code_q <= code_d;
      pend_q <= pend_d;
      req_q  <= req_s;
      a_n_q  <= (st_d == HOLD) ? ~code_d : '1;
      gs_n_q <= (st_d != HOLD);
      eo_n_q <= ~(en & (pend_d == '0) & (st_d == IDLE));
    end
  end

  assign a_n_o     = a_n_q;
  assign gs_n_o    = gs_n_q;
  assign valid_o   = ~gs_n_q;
  assign eo_n_o    = eo_n_q;
  assign pending_o = pend_q;

endmodule
